pipelined_cla_addsub: RTL and testbench
=======================================

// Module: pipelined_cla_addsub
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the
//  single-cycle 4-bit CLA in the datapath library.
//  - Splits WIDTH into BLOCK-bit lookahead groups, spread over STAGES register stages.
//  - Adds subtract mode, carry-in, carry-out, signed overflow and valid/ready flow control.
//  - Sits between operand-fetch and writeback in the ALU datapath.
// PARAMETERS
//  WIDTH   32  operand/result width; must be a multiple of BLOCK
//  BLOCK    4  bits per lookahead group (G/P group logic)
//  STAGES   2  pipeline depth; (WIDTH/BLOCK) % STAGES == 0; latency = STAGES
// PORTS
//  clk       in   1      clock; all state updates on posedge
//  rst       in   1      asynchronous reset, active-low (rst==0 resets)
//  i_valid   in   1      operand beat valid
//  o_ready   out  1      block can accept a beat this cycle
//  i_add1    in   WIDTH  operand A
//  i_add2    in   WIDTH  operand B
//  i_cin     in   1      carry-in (add) / borrow-in (sub)
//  i_sub     in   1      1: A - B - i_cin; 0: A + B + i_cin
//  o_valid   out  1      result beat valid
//  i_ready   in   1      downstream accepts result
//  o_result  out  WIDTH  sum/difference
//  o_cout    out  1      carry-out; in sub mode 1 = no borrow
//  o_ovf     out  1      signed (two's complement) overflow
// BEHAVIOUR
//  - Reset (rst low, async): all stage valid bits, data regs, o_result, o_cout and o_ovf clear to 0.
//    o_ready is 1 one cycle after rst deasserts.
//  - Operand prep:
//    - Beff = i_add2 ^ {WIDTH{i_sub}}; ceff = i_cin ^ i_sub.
//    - Per bit: G = A & Beff, P = A | Beff.
//  - Group logic: group k uses Ggrp/Pggrp lookahead; carry into group k+1 =
//    Ggrp_k | (Pgrp_k & c_k).
//  - Stage s resolves groups [s*N/STAGES, (s+1)*N/STAGES) (N = WIDTH/BLOCK).
//    - Its sum bits, pending operand bits and the carry out of its last group are registered.
//    - Stage 0 takes ceff as its carry-in.
//  - Latency: a beat accepted at edge t appears on o_valid/o_result after edge t+STAGES-1 when
//    never stalled. One beat per cycle throughput.
//  - o_cout = carry out of MSB group (ceff chain). o_ovf = c_in(MSB) ^ c_out(MSB).
//  - Flow control (global stall):
//    - adv = ~o_valid | i_ready; o_ready = adv.
//    - Transfer in when i_valid & adv; stage regs and valid bits shift only when adv.
//    - Bubbles (valid=0) propagate; data regs of invalid stages are don't-care except after reset.
//  - o_valid & ~i_ready: every stage holds; o_result/o_cout/o_ovf are stable until accepted.
//  - Simultaneous input accept and output accept in one cycle: both take effect, nothing dropped.
//  - Wrap-around: results are modulo 2^WIDTH; carry reported only via o_cout.
//  - Reset mid-operation: all in-flight beats are discarded, nothing is emitted for them.
// CONFIGURATION
//  CLA_SATURATE_EN defined:
//  - On o_ovf=1, o_result clamps to signed max (0x7F..F) if A was non-negative, else signed
//    min (0x80..0). A = i_add1.
//  - o_ovf still asserts and o_cout is unchanged.
//  - Adds one mux after the last stage; latency unchanged.
//  CLA_SATURATE_EN undefined: o_result is the wrapped result.
// TESTING (WIDTH=8, BLOCK=4, STAGES=2 unless noted)
//  1. Add 0x7F+0x01, cin=0 -> o_result=0x80, o_cout=0, o_ovf=1, o_valid 2 cycles after accept.
//     With CLA_SATURATE_EN -> o_result=0x7F.
//  2. Add 0xFF+0x01 -> 0x00, cout=1, ovf=0. Sub 0x05-0x07, cin=0 -> 0xFE, cout=0, ovf=0.
//     Sub 0x80-0x01 -> 0x7F, ovf=1.
//  3. Stream 8 back-to-back beats with i_ready=1 -> 8 consecutive o_valid cycles, in order,
//     all results matching the model.
//  4. Stream 4 beats, drop i_ready for 3 cycles while o_valid=1:
//     - o_ready=0 and o_result stable during the hold.
//     - All 4 results delivered in order once i_ready returns.
//  5. Assert rst low with 2 beats in flight -> o_valid=0 and o_result=0 immediately.
//     No stale beat appears after release.
//  6. WIDTH=32, BLOCK=4, STAGES=4: 10k random add/sub/cin ops with random i_valid/i_ready ->
//     scoreboard match, latency 4.

Source files
------------

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control and a global stall.
// Optional build macro CLA_SATURATE_EN clamps overflowing results to signed max/min.
module pipelined_cla_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BLOCK  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int unsigned SW  = WIDTH / STAGES;  // bits resolved per stage
  localparam int unsigned GPS = SW / BLOCK;      // lookahead groups per stage

  logic adv;
  logic take;
  logic rdy_q;

  assign adv     = ~o_valid | i_ready;
  assign o_ready = rdy_q & adv;
  assign take    = i_valid & o_ready;

  // Holds off acceptance for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned Lo = s * SW;
    localparam int unsigned Hi = Lo + SW;

    logic [WIDTH-1:Lo] a_in;
    logic [WIDTH-1:Lo] b_in;
    logic              c_in;
    logic              v_in;
    logic [SW-1:0]     sum;
    logic              c_out;
    logic [Hi-1:0]     res_d;
    logic [Hi-1:0]     res_q;
    logic              v_q;
    logic              c_q;

    if (s == 0) begin : g_src
      assign a_in  = i_add1;
      assign b_in  = i_add2 ^ {WIDTH{i_sub}};
      assign c_in  = i_cin ^ i_sub;
      assign v_in  = take;
      assign res_d = sum;
    end else begin : g_src
      assign a_in  = g_stage[s-1].g_pend.a_q;
      assign b_in  = g_stage[s-1].g_pend.b_q;
      assign c_in  = g_stage[s-1].c_q;
      assign v_in  = g_stage[s-1].v_q;
      assign res_d = {sum, g_stage[s-1].res_q};
    end

    // Running group generate/propagate gives each bit its lookahead carry; the group's
    // final G/P then forms the carry into the next group.
    always_comb begin : p_cla
      logic        c;
      logic        gg;
      logic        pg;
      int unsigned idx;
      c   = c_in;
      gg  = 1'b0;
      pg  = 1'b1;
      idx = 0;
      sum = '0;
      for (int unsigned k = 0; k < GPS; k++) begin
        gg = 1'b0;
        pg = 1'b1;
        for (int unsigned j = 0; j < BLOCK; j++) begin
          idx = Lo + k * BLOCK + j;
          sum[k*BLOCK+j] = a_in[idx] ^ b_in[idx] ^ (gg | (pg & c));
          gg = (a_in[idx] & b_in[idx]) | ((a_in[idx] | b_in[idx]) & gg);
          pg = pg & (a_in[idx] | b_in[idx]);
        end
        c = gg | (pg & c);
      end
      c_out = c;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        res_q <= '0;
      end else if (adv) begin
        v_q   <= v_in;
        c_q   <= c_out;
        res_q <= res_d;
      end
    end

    if (s < STAGES - 1) begin : g_pend
      logic [WIDTH-1:Hi] a_q;
      logic [WIDTH-1:Hi] b_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[WIDTH-1:Hi];
          b_q <= b_in[WIDTH-1:Hi];
        end
      end
    end else begin : g_last
      logic ovf_d;
      logic ovf_q;

      // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
      assign ovf_d = (sum[SW-1] ^ a_in[WIDTH-1] ^ b_in[WIDTH-1]) ^ c_out;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_d;
        end
      end

`ifdef CLA_SATURATE_EN
      logic sign_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sign_q <= 1'b0;
        end else if (adv) begin
          sign_q <= a_in[WIDTH-1];
        end
      end
`endif
    end
  end

  logic [WIDTH-1:0] res_last;

  assign res_last = g_stage[STAGES-1].res_q;
  assign o_valid  = g_stage[STAGES-1].v_q;
  assign o_cout   = g_stage[STAGES-1].c_q;
  assign o_ovf    = g_stage[STAGES-1].g_last.ovf_q;

`ifdef CLA_SATURATE_EN
  always_comb begin
    o_result = res_last;
    if (o_ovf) begin
      o_result = g_stage[STAGES-1].g_last.sign_q ? {1'b1, {(WIDTH-1){1'b0}}}
                                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign o_result = res_last;
`endif

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench: an 8-bit/2-stage and a 32-bit/4-stage instance checked against an
// arithmetic model via per-instance scoreboards, plus directed literal vectors.
module tb_pipelined_cla_addsub;

  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 8-bit instance signals
  logic       v8 = 0, cin8 = 0, sub8 = 0, ir8 = 1;
  logic [7:0] a8 = 0, b8 = 0;
  logic       rdy8, ov8, cout8, ovf8;
  logic [7:0] res8;

  // 32-bit instance signals
  logic        v32 = 0, cin32 = 0, sub32 = 0, ir32 = 1;
  logic [31:0] a32 = 0, b32 = 0;
  logic        rdy32, ov32, cout32, ovf32;
  logic [31:0] res32;

  pipelined_cla_addsub #(.WIDTH(8), .BLOCK(4), .STAGES(2)) u_dut8 (
    .clk(clk), .rst(rst), .i_valid(v8), .o_ready(rdy8), .i_add1(a8), .i_add2(b8),
    .i_cin(cin8), .i_sub(sub8), .o_valid(ov8), .i_ready(ir8), .o_result(res8),
    .o_cout(cout8), .o_ovf(ovf8)
  );

  pipelined_cla_addsub #(.WIDTH(32), .BLOCK(4), .STAGES(4)) u_dut32 (
    .clk(clk), .rst(rst), .i_valid(v32), .o_ready(rdy32), .i_add1(a32), .i_add2(b32),
    .i_cin(cin32), .i_sub(sub32), .o_valid(ov32), .i_ready(ir32), .o_result(res32),
    .o_cout(cout32), .o_ovf(ovf32)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Plain signed/unsigned arithmetic in 64 bits.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    exp_t   e;
    longint ua, ub, ci, sa, sb, sr, ur, pw, half;
    ua = a; ub = b; ci = cin;
    pw   = longint'(1) << w;
    half = longint'(1) << (w - 1);
    sa = (ua >= half) ? ua - pw : ua;
    sb = (ub >= half) ? ub - pw : ub;
    if (sub) begin
      sr = sa - sb - ci;
      ur = ua - ub - ci;
      e.cout = (ur >= 0);
    end else begin
      sr = sa + sb + ci;
      ur = ua + ub + ci;
      e.cout = (ur >= pw);
    end
    e.res = 32'(ur & (pw - 1));
    e.ovf = (sr >= half) || (sr < -half);
`ifdef CLA_SATURATE_EN
    if (e.ovf) e.res = (sa >= 0) ? 32'(half - 1) : 32'(pw - half);
`endif
    return e;
  endfunction

  exp_t q8[$];
  exp_t q32[$];
  exp_t e8, e32;

  always @(negedge clk) begin
    if (!rst) begin
      q8.delete();
    end else begin
      if (ov8 && !ir8 && q8.size() != 0) chk("hold8", {24'b0, res8}, q8[0].res);
      if (ov8 && ir8) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL stale8: got result %h, expected no result", res8);
        end else begin
          e8 = q8.pop_front();
          chk("res8", {24'b0, res8}, e8.res);
          chk("cout8", {31'b0, cout8}, {31'b0, e8.cout});
          chk("ovf8", {31'b0, ovf8}, {31'b0, e8.ovf});
        end
      end
      if (v8 && rdy8) q8.push_back(model(8, {24'b0, a8}, {24'b0, b8}, cin8, sub8));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      q32.delete();
    end else begin
      if (ov32 && !ir32 && q32.size() != 0) chk("hold32", res32, q32[0].res);
      if (ov32 && ir32) begin
        if (q32.size() == 0) begin
          checks++; errors++;
          $display("FAIL stale32: got result %h, expected no result", res32);
        end else begin
          e32 = q32.pop_front();
          chk("res32", res32, e32.res);
          chk("cout32", {31'b0, cout32}, {31'b0, e32.cout});
          chk("ovf32", {31'b0, ovf32}, {31'b0, e32.ovf});
        end
      end
      if (v32 && rdy32) q32.push_back(model(32, a32, b32, cin32, sub32));
    end
  end

  // Present one beat and hold it until accepted; returns just after the accepting edge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub);
    logic acc;
    int   n;
    v8 = 1'b1; a8 = a; b8 = b; cin8 = cin; sub8 = sub;
    n = 0;
    do begin
      @(negedge clk); acc = rdy8;
      @(posedge clk); #1; n++;
    end while (!acc && n < 50);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send8_timeout: got no accept in %0d cycles, expected accept", n);
    end
    v8 = 1'b0;
  endtask

  task automatic result8(input string nm, input logic [7:0] r, input logic c, input logic o,
                         input int lat);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!ov8 && k < 20);
    chk({nm, "_valid"}, {31'b0, ov8}, 32'd1);
    chk({nm, "_lat"}, k, lat);
    chk({nm, "_res"}, {24'b0, res8}, {24'b0, r});
    chk({nm, "_cout"}, {31'b0, cout8}, {31'b0, c});
    chk({nm, "_ovf"}, {31'b0, ovf8}, {31'b0, o});
    @(posedge clk); #1;
  endtask

  task automatic stream_test();
    int run, maxrun, total;
    run = 0; maxrun = 0; total = 0;
    fork
      for (int i = 0; i < 8; i++) send8(8'(i * 17 + 3), 8'(i * 29 + 100), 1'(i), 1'(i >> 1));
      for (int i = 0; i < 14; i++) begin
        @(negedge clk);
        if (ov8) begin
          run++; total++;
          if (run > maxrun) maxrun = run;
        end else begin
          run = 0;
        end
      end
    join
    chk("stream_run", maxrun, 8);
    chk("stream_total", total, 8);
  endtask

  task automatic stall_test();
    int k;
    k = 0;
    fork
      for (int i = 0; i < 4; i++) send8(8'(i * 55 + 9), 8'(200 - i * 31), 1'(i >> 1), 1'(i));
      begin
        do begin @(negedge clk); k++; end while (!ov8 && k < 20);
        @(posedge clk); #1;
        ir8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_ready", {31'b0, rdy8}, 32'd0);
          chk("stall_valid", {31'b0, ov8}, 32'd1);
        end
        @(posedge clk); #1;
        ir8 = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("stall_drain", q8.size(), 0);
  endtask

  initial begin
    int n, cyc, k;
    #3;
    chk("rst_valid", {31'b0, ov8}, 32'd0);
    chk("rst_res", {24'b0, res8}, 32'd0);
    chk("rst_cout", {31'b0, cout8}, 32'd0);
    chk("rst_ovf", {31'b0, ovf8}, 32'd0);
    chk("rst_valid32", {31'b0, ov32}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'b0, rdy8}, 32'd1);

    // Directed vectors
    send8(8'h7F, 8'h01, 1'b0, 1'b0);
`ifdef CLA_SATURATE_EN
    result8("add_ovf", 8'h7F, 1'b0, 1'b1, 2);
`else
    result8("add_ovf", 8'h80, 1'b0, 1'b1, 2);
`endif
    send8(8'hFF, 8'h01, 1'b0, 1'b0);
    result8("add_wrap", 8'h00, 1'b1, 1'b0, 2);
    send8(8'h05, 8'h07, 1'b0, 1'b1);
    result8("sub_borrow", 8'hFE, 1'b0, 1'b0, 2);
    send8(8'h80, 8'h01, 1'b0, 1'b1);
`ifdef CLA_SATURATE_EN
    result8("sub_ovf", 8'h80, 1'b1, 1'b1, 2);
`else
    result8("sub_ovf", 8'h7F, 1'b1, 1'b1, 2);
`endif
    send8(8'h12, 8'h34, 1'b1, 1'b0);
    result8("add_cin", 8'h47, 1'b0, 1'b0, 2);
    send8(8'h10, 8'h01, 1'b1, 1'b1);
    result8("sub_cin", 8'h0E, 1'b1, 1'b0, 2);

    repeat (3) @(posedge clk);
    #1;
    stream_test();
    repeat (3) @(posedge clk);
    #1;
    stall_test();

    // Reset with two beats in flight
    send8(8'h21, 8'h42, 1'b0, 1'b0);
    send8(8'h99, 8'h11, 1'b1, 1'b1);
    rst = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, ov8}, 32'd0);
    chk("midrst_res", {24'b0, res8}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", {31'b0, rdy8}, 32'd1);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov8) k++;
    end
    chk("midrst_no_stale", k, 0);
    @(posedge clk); #1;

    // 32-bit instance: latency pin, then random traffic
    v32 = 1'b1; a32 = 32'h7FFF_FFFF; b32 = 32'h1; cin32 = 1'b0; sub32 = 1'b0;
    @(posedge clk); #1;
    v32 = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!ov32 && k < 20);
    chk("lat32", k, 4);
`ifdef CLA_SATURATE_EN
    chk("add_ovf32", res32, 32'h7FFF_FFFF);
`else
    chk("add_ovf32", res32, 32'h8000_0000);
`endif
    chk("add_ovf32_flag", {31'b0, ovf32}, 32'd1);
    @(posedge clk); #1;

    n = 0; cyc = 0;
    while (n < 10000 && cyc < 60000) begin
      v32   = ($urandom_range(0, 3) != 0);
      a32   = $urandom;
      b32   = $urandom;
      cin32 = 1'($urandom_range(0, 1));
      sub32 = 1'($urandom_range(0, 1));
      ir32  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (v32 && rdy32) n++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand32_count", n, 10000);
    v32 = 1'b0; ir32 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain32", q32.size(), 0);
    chk("drain8", q8.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
